// File: rtl/lfsr_nibble_packer_if.sv
// lfsr_nibble_packer_if: nibble input, word output and status signals of the packer
interface lfsr_nibble_packer_if #(
    parameter int NIB_W  = 4,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
);
    logic [NIB_W-1:0]        r;
    logic                    r_valid;
    logic                    flush;
    logic [WORD_W-1:0]       word_data;
    logic                    word_valid;
    logic                    word_ready;
    logic [$clog2(DEPTH):0]  fill_level;
    logic                    overflow;
    logic [7:0]              drop_cnt;
    logic [15:0]             word_cnt;

    modport slave (
        input  r, r_valid, flush, word_ready,
        output word_data, word_valid, fill_level, overflow, drop_cnt, word_cnt
    );

    modport master (
        output r, r_valid, flush, word_ready,
        input  word_data, word_valid, fill_level, overflow, drop_cnt, word_cnt
    );
endinterface

// File: rtl/lfsr_nibble_packer.sv
// lfsr_nibble_packer: packs LFSR nibbles LSB-first into words, buffers them in a show-ahead FIFO
module lfsr_nibble_packer #(
    parameter int NIB_W  = 4,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    lfsr_nibble_packer_if.slave  bus
);
    localparam int NIBBLES = WORD_W / NIB_W;
    localparam int IW      = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam int AW      = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [IW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] acc_q, acc_d, acc_nib;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        drop_q, drop_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic              last, push, pop, full, accept, drop;

    // Word assembly, push/pop arbitration and next-state for all counters.
    // The accumulator is cleared on every push, so OR-ing the new nibble in
    // leaves the unfilled upper nibbles at zero for a flushed partial word.
    always_comb begin
        acc_nib = bus.r_valid ? acc_q | (WORD_W'(bus.r) << (32'(idx_q) * NIB_W)) : acc_q;
        last    = bus.r_valid && idx_q == IW'(NIBBLES - 1);
        push    = last || (bus.flush && (idx_q != '0 || bus.r_valid));
        pop     = cnt_q != '0 && bus.word_ready;
        full    = cnt_q == (AW+1)'(DEPTH);
        accept  = push && (!full || pop);
        drop    = push && full && !pop;
        idx_d   = push ? '0 : idx_q + IW'(bus.r_valid);
        acc_d   = push ? '0 : acc_nib;
        wr_d    = accept ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
        ovf_d   = ovf_q || drop;
        drop_d  = drop_q + 8'(drop && drop_q != 8'hFF);
        wcnt_d  = wcnt_q + 16'(pop);
    end

    // Control and status registers; reset discards any partial word and FIFO contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q  <= '0;
            acc_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
            wcnt_q <= '0;
        end else begin
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
            wcnt_q <= wcnt_d;
        end
    end

    // FIFO storage; stale entries are never visible because the output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (reset && accept) mem_q[wr_q] <= acc_nib;
    end

    assign bus.word_valid = cnt_q != '0;
    assign bus.word_data  = cnt_q != '0 ? mem_q[rd_q] : '0;
    assign bus.fill_level = cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.drop_cnt   = drop_q;
    assign bus.word_cnt   = wcnt_q;
endmodule
